// File: rtl/mbimager_mod_pkg.sv
// Shared types and field widths for the modulation sequencer and the clkgen wrappers.
package mbimager_mod_pkg;

    localparam int PHASE_W = 5;
    localparam int DUTY_W  = 4;
    localparam int FREQ_W  = 3;

    typedef enum logic [1:0] {
        SEQ_IDLE    = 2'd0,
        SEQ_DRAIN   = 2'd1,
        SEQ_EXPOSE  = 2'd2,
        SEQ_READOUT = 2'd3
    } seq_state_t;

endpackage

// File: rtl/mod_period_counter.sv
// Exposure timer: counts 2^PERIOD_W CLK_IN cycles per modulation period and
// pulses expired on the final cycle of the last loaded period.
module mod_period_counter #(
    parameter int PERIOD_W = 17,
    parameter int EXP_W    = 12
) (
    input  logic             CLK_IN,
    input  logic             RST,
    input  logic             load,
    input  logic             en,
    input  logic [EXP_W-1:0] num_per,
    output logic             expired
);

    logic [PERIOD_W-1:0] cyc_cnt_reg;
    logic [EXP_W-1:0]    per_cnt_reg;
    logic                cyc_wrap;

    assign cyc_wrap = &cyc_cnt_reg;
    assign expired  = en && cyc_wrap && (per_cnt_reg == '0);

    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            cyc_cnt_reg <= '0;
            per_cnt_reg <= '0;
        end else if (load) begin
            cyc_cnt_reg <= '0;
            // A zero period count runs as a single period.
            per_cnt_reg <= (num_per == '0) ? '0 : num_per - EXP_W'(1);
        end else if (en) begin
            cyc_cnt_reg <= cyc_cnt_reg + PERIOD_W'(1);
            if (cyc_wrap && (per_cnt_reg != '0))
                per_cnt_reg <= per_cnt_reg - EXP_W'(1);
        end
    end

endmodule

// File: rtl/mod_exposure_sequencer.sv
// Multi-subframe exposure sequencer driving the non-overlap modulation clkgen.
// Optional ABORT input is enabled by defining MOD_SEQ_ABORT_EN.
module mod_exposure_sequencer
    import mbimager_mod_pkg::*;
#(
    parameter int PERIOD_W  = 17,
    parameter int DRAIN_CYC = 64,
    parameter int EXP_W     = 12,
    parameter int SUB_W     = 4
) (
    input  logic               CLK_IN,
    input  logic               RST,
    input  logic               START,
    input  logic [SUB_W-1:0]   CFG_NUM_SUB,
    input  logic [EXP_W-1:0]   CFG_EXP_PER,
    input  logic [PHASE_W-1:0] CFG_PHASE0,
    input  logic [PHASE_W-1:0] CFG_PHASE_STEP,
    input  logic [DUTY_W-1:0]  CFG_DUTY,
    input  logic [FREQ_W-1:0]  CFG_FREQ,
    input  logic               CFG_HIGH_FREQ,
    input  logic               READOUT_ACK,
`ifdef MOD_SEQ_ABORT_EN
    input  logic               ABORT,
`endif
    output logic               DRAIN_B,
    output logic [PHASE_W-1:0] PHASE_SEL,
    output logic [DUTY_W-1:0]  DUTY_SEL,
    output logic [FREQ_W-1:0]  FREQ_SEL,
    output logic               FLAG_HIGH_FREQ,
    output logic [1:0]         OPTION_SEL,
    output logic               READOUT_REQ,
    output logic [SUB_W-1:0]   SUB_IDX,
    output logic               BUSY,
    output logic               DONE
);

    localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    seq_state_t         state_reg, state_next;
    logic [DRAIN_W-1:0] drain_cnt_reg;
    logic [SUB_W-1:0]   num_sub_reg, sub_idx_reg, last_idx;
    logic [EXP_W-1:0]   exp_per_reg;
    logic [PHASE_W-1:0] phase_step_reg, phase_sel_reg;
    logic [DUTY_W-1:0]  duty_sel_reg;
    logic [FREQ_W-1:0]  freq_sel_reg;
    logic               high_freq_reg;
    logic               drain_b_reg, readout_req_reg, busy_reg, done_reg;
    logic               drain_b_next, readout_req_next, busy_next, done_next;
    logic               abort_hit, last_sub, period_load, period_expired;

`ifdef MOD_SEQ_ABORT_EN
    assign abort_hit = ABORT;
`else
    assign abort_hit = 1'b0;
`endif

    assign last_idx    = (num_sub_reg == '0) ? '0 : num_sub_reg - SUB_W'(1);
    assign last_sub    = (sub_idx_reg == last_idx);
    assign period_load = (state_reg == SEQ_DRAIN) && (state_next == SEQ_EXPOSE);

    mod_period_counter #(
        .PERIOD_W (PERIOD_W),
        .EXP_W    (EXP_W)
    ) u_period_counter (
        .CLK_IN  (CLK_IN),
        .RST     (RST),
        .load    (period_load),
        .en      (state_reg == SEQ_EXPOSE),
        .num_per (exp_per_reg),
        .expired (period_expired)
    );

    // State and registered outputs.
    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            state_reg       <= SEQ_IDLE;
            drain_b_reg     <= 1'b0;
            readout_req_reg <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            drain_b_reg     <= drain_b_next;
            readout_req_reg <= readout_req_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            SEQ_IDLE:    if (START) state_next = SEQ_DRAIN;
            SEQ_DRAIN:   if (drain_cnt_reg == '0) state_next = SEQ_EXPOSE;
            SEQ_EXPOSE:  if (period_expired) state_next = SEQ_READOUT;
            SEQ_READOUT: if (READOUT_ACK) state_next = last_sub ? SEQ_IDLE : SEQ_DRAIN;
            default:     state_next = SEQ_IDLE;
        endcase
        if ((state_reg != SEQ_IDLE) && abort_hit)
            state_next = SEQ_IDLE;
    end

    // Outputs are derived from the next state so they line up with state_reg.
    always_comb begin
        drain_b_next     = (state_next == SEQ_EXPOSE);
        readout_req_next = (state_next == SEQ_READOUT);
        busy_next        = (state_next != SEQ_IDLE);
        done_next        = (state_reg == SEQ_READOUT) && READOUT_ACK && last_sub && !abort_hit;
    end

    // Config latches, subframe index and phase stepping.
    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            num_sub_reg    <= '0;
            exp_per_reg    <= '0;
            phase_step_reg <= '0;
            phase_sel_reg  <= '0;
            duty_sel_reg   <= '0;
            freq_sel_reg   <= '0;
            high_freq_reg  <= 1'b0;
            sub_idx_reg    <= '0;
        end else if ((state_reg == SEQ_IDLE) && START) begin
            num_sub_reg    <= CFG_NUM_SUB;
            exp_per_reg    <= CFG_EXP_PER;
            phase_step_reg <= CFG_PHASE_STEP;
            phase_sel_reg  <= CFG_PHASE0;
            duty_sel_reg   <= CFG_DUTY;
            freq_sel_reg   <= CFG_FREQ;
            high_freq_reg  <= CFG_HIGH_FREQ;
            sub_idx_reg    <= '0;
        end else if ((state_reg != SEQ_IDLE) && abort_hit) begin
            sub_idx_reg <= '0;
        end else if ((state_reg == SEQ_READOUT) && READOUT_ACK && !last_sub) begin
            sub_idx_reg   <= sub_idx_reg + SUB_W'(1);
            // DRAIN_B is already low here, so the clkgen never sees the step mid-exposure.
            phase_sel_reg <= phase_sel_reg + phase_step_reg;
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            drain_cnt_reg <= '0;
        end else if ((state_next == SEQ_DRAIN) && (state_reg != SEQ_DRAIN)) begin
            drain_cnt_reg <= DRAIN_W'(DRAIN_CYC - 1);
        end else if ((state_reg == SEQ_DRAIN) && (drain_cnt_reg != '0)) begin
            drain_cnt_reg <= drain_cnt_reg - DRAIN_W'(1);
        end
    end

    assign DRAIN_B        = drain_b_reg;
    assign PHASE_SEL      = phase_sel_reg;
    assign DUTY_SEL       = duty_sel_reg;
    assign FREQ_SEL       = freq_sel_reg;
    assign FLAG_HIGH_FREQ = high_freq_reg;
    assign OPTION_SEL     = 2'b00;
    assign READOUT_REQ    = readout_req_reg;
    assign SUB_IDX        = sub_idx_reg;
    assign BUSY           = busy_reg;
    assign DONE           = done_reg;

endmodule

// File: tb/tb_mod_exposure_sequencer.sv
// Scoreboard bench for mod_exposure_sequencer (PERIOD_W=4, DRAIN_CYC=3).
// Define MOD_SEQ_ABORT_EN to also exercise the ABORT input.
module tb_mod_exposure_sequencer;

    localparam int PERIOD_W  = 4;
    localparam int DRAIN_CYC = 3;
    localparam int EXP_W     = 12;
    localparam int SUB_W     = 4;

    localparam int K_READOUT = 1;
    localparam int K_DONE    = 2;

    typedef struct {
        int kind;
        int sub;
        int phase;
        int drain;
        int expo;
        int phase_bad;
    } rec_t;

    logic             CLK_IN = 1'b0;
    logic             RST = 1'b1;
    logic             START = 1'b0;
    logic [SUB_W-1:0] CFG_NUM_SUB = '0;
    logic [EXP_W-1:0] CFG_EXP_PER = '0;
    logic [4:0]       CFG_PHASE0 = '0;
    logic [4:0]       CFG_PHASE_STEP = '0;
    logic [3:0]       CFG_DUTY = '0;
    logic [2:0]       CFG_FREQ = '0;
    logic             CFG_HIGH_FREQ = 1'b0;
    logic             READOUT_ACK = 1'b0;
    logic             ABORT = 1'b0;
    logic             DRAIN_B;
    logic [4:0]       PHASE_SEL;
    logic [3:0]       DUTY_SEL;
    logic [2:0]       FREQ_SEL;
    logic             FLAG_HIGH_FREQ;
    logic [1:0]       OPTION_SEL;
    logic             READOUT_REQ;
    logic [SUB_W-1:0] SUB_IDX;
    logic             BUSY;
    logic             DONE;

    int   checks = 0;
    int   failures = 0;
    rec_t exp_q[$];

    always #5 CLK_IN = ~CLK_IN;

    mod_exposure_sequencer #(
        .PERIOD_W  (PERIOD_W),
        .DRAIN_CYC (DRAIN_CYC),
        .EXP_W     (EXP_W),
        .SUB_W     (SUB_W)
    ) dut (
        .CLK_IN         (CLK_IN),
        .RST            (RST),
        .START          (START),
        .CFG_NUM_SUB    (CFG_NUM_SUB),
        .CFG_EXP_PER    (CFG_EXP_PER),
        .CFG_PHASE0     (CFG_PHASE0),
        .CFG_PHASE_STEP (CFG_PHASE_STEP),
        .CFG_DUTY       (CFG_DUTY),
        .CFG_FREQ       (CFG_FREQ),
        .CFG_HIGH_FREQ  (CFG_HIGH_FREQ),
        .READOUT_ACK    (READOUT_ACK),
`ifdef MOD_SEQ_ABORT_EN
        .ABORT          (ABORT),
`endif
        .DRAIN_B        (DRAIN_B),
        .PHASE_SEL      (PHASE_SEL),
        .DUTY_SEL       (DUTY_SEL),
        .FREQ_SEL       (FREQ_SEL),
        .FLAG_HIGH_FREQ (FLAG_HIGH_FREQ),
        .OPTION_SEL     (OPTION_SEL),
        .READOUT_REQ    (READOUT_REQ),
        .SUB_IDX        (SUB_IDX),
        .BUSY           (BUSY),
        .DONE           (DONE)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_ro(input int sub, input int phase, input int expo);
        rec_t r;
        r.kind = K_READOUT; r.sub = sub; r.phase = phase;
        r.drain = DRAIN_CYC; r.expo = expo; r.phase_bad = 0;
        exp_q.push_back(r);
    endtask

    task automatic push_done();
        rec_t r;
        r.kind = K_DONE; r.sub = 0; r.phase = 0; r.drain = 0; r.expo = 0; r.phase_bad = 0;
        exp_q.push_back(r);
    endtask

    // Monitor: builds one record per READOUT_REQ rise or DONE pulse and scores it.
    int   mon_drain = 0;
    int   mon_expo = 0;
    int   mon_phase = 0;
    int   mon_bad = 0;
    logic req_prev = 1'b0;

    task automatic score(input rec_t obs);
        rec_t e;
        $display("txn kind=%0d sub=%0d phase=%0d drain=%0d expo=%0d phase_bad=%0d @%0t",
                 obs.kind, obs.sub, obs.phase, obs.drain, obs.expo, obs.phase_bad, $time);
        if (exp_q.size() == 0) begin
            chk("unexpected_txn_kind", obs.kind, 0);
            return;
        end
        e = exp_q.pop_front();
        chk("txn_kind", obs.kind, e.kind);
        if (e.kind == K_READOUT && obs.kind == K_READOUT) begin
            chk("txn_sub_idx", obs.sub, e.sub);
            chk("txn_phase_sel", obs.phase, e.phase);
            chk("txn_drain_len", obs.drain, e.drain);
            chk("txn_expose_len", obs.expo, e.expo);
            chk("txn_phase_stable", obs.phase_bad, e.phase_bad);
        end
    endtask

    always @(negedge CLK_IN) begin
        rec_t obs;
        if (RST || !BUSY) begin
            mon_drain = 0; mon_expo = 0; mon_bad = 0;
        end else if (DRAIN_B) begin
            if (mon_expo == 0) mon_phase = int'(PHASE_SEL);
            else if (int'(PHASE_SEL) != mon_phase) mon_bad = 1;
            mon_expo++;
        end else if (!READOUT_REQ) begin
            mon_drain++;
        end
        if (!RST && READOUT_REQ && !req_prev) begin
            obs.kind = K_READOUT; obs.sub = int'(SUB_IDX); obs.phase = int'(PHASE_SEL);
            obs.drain = mon_drain; obs.expo = mon_expo; obs.phase_bad = mon_bad;
            score(obs);
            mon_drain = 0; mon_expo = 0; mon_bad = 0;
        end
        if (!RST && DONE) begin
            obs.kind = K_DONE; obs.sub = 0; obs.phase = 0; obs.drain = 0; obs.expo = 0; obs.phase_bad = 0;
            score(obs);
        end
        req_prev = READOUT_REQ;
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK_IN);
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (!READOUT_REQ && n < budget) begin @(negedge CLK_IN); n++; end
        chk("wait_readout_req_timeout", int'(READOUT_REQ), 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (BUSY && n < budget) begin @(negedge CLK_IN); n++; end
        chk("wait_idle_timeout", int'(BUSY), 0);
    endtask

    task automatic wait_expose(input int budget);
        int n = 0;
        while (!DRAIN_B && n < budget) begin @(negedge CLK_IN); n++; end
        chk("wait_expose_timeout", int'(DRAIN_B), 1);
    endtask

    task automatic set_cfg(input int nsub, input int nexp, input int ph0, input int step,
                           input int duty, input int freq, input int hf);
        CFG_NUM_SUB = SUB_W'(nsub);
        CFG_EXP_PER = EXP_W'(nexp);
        CFG_PHASE0 = 5'(ph0);
        CFG_PHASE_STEP = 5'(step);
        CFG_DUTY = 4'(duty);
        CFG_FREQ = 3'(freq);
        CFG_HIGH_FREQ = hf[0];
    endtask

    task automatic pulse_start();
        START = 1'b1; @(negedge CLK_IN); START = 1'b0;
    endtask

    task automatic pulse_ack();
        READOUT_ACK = 1'b1; @(negedge CLK_IN); READOUT_ACK = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_drain_b"}, int'(DRAIN_B), 0);
        chk({tag, "_busy"}, int'(BUSY), 0);
        chk({tag, "_readout_req"}, int'(READOUT_REQ), 0);
        chk({tag, "_done"}, int'(DONE), 0);
        chk({tag, "_sub_idx"}, int'(SUB_IDX), 0);
    endtask

    initial begin
        int stable;

        // Reset state
        cycles(3);
        chk_idle_outputs("reset");
        chk("reset_phase_sel", int'(PHASE_SEL), 0);
        chk("reset_duty_sel", int'(DUTY_SEL), 0);
        chk("reset_freq_sel", int'(FREQ_SEL), 0);
        chk("reset_high_freq", int'(FLAG_HIGH_FREQ), 0);
        chk("option_sel", int'(OPTION_SEL), 0);
        RST = 1'b0;
        cycles(2);

        // Reset in the middle of EXPOSE: no records expected afterwards.
        set_cfg(1, 3, 9, 1, 2, 1, 0);
        pulse_start();
        chk("start_busy", int'(BUSY), 1);
        wait_expose(20);
        cycles(5);
        RST = 1'b1; @(negedge CLK_IN);
        chk_idle_outputs("mid_reset");
        chk("mid_reset_phase_sel", int'(PHASE_SEL), 0);
        RST = 1'b0;
        cycles(60);
        chk_idle_outputs("after_mid_reset");

        // Single subframe, ACK one cycle after READOUT_REQ.
        set_cfg(1, 2, 5, 3, 9, 5, 1);
        push_ro(0, 5, 32);
        push_done();
        pulse_start();
        wait_req(100);
        @(negedge CLK_IN);
        chk("ro_hold_drain_b", int'(DRAIN_B), 0);
        pulse_ack();
        wait_idle(20);
        chk("single_phase_hold", int'(PHASE_SEL), 5);
        chk("single_duty_sel", int'(DUTY_SEL), 9);
        chk("single_freq_sel", int'(FREQ_SEL), 5);
        chk("single_high_freq", int'(FLAG_HIGH_FREQ), 1);
        cycles(3);

        // Phase sweep with wrap, ACK held high throughout.
        set_cfg(4, 1, 28, 4, 3, 2, 0);
        push_ro(0, 28, 16);
        push_ro(1, 0, 16);
        push_ro(2, 4, 16);
        push_ro(3, 8, 16);
        push_done();
        READOUT_ACK = 1'b1;
        pulse_start();
        wait_idle(300);
        READOUT_ACK = 1'b0;
        chk("sweep_sub_idx_final", int'(SUB_IDX), 3);
        cycles(3);

        // Zero config behaves as one subframe of one period.
        set_cfg(0, 0, 7, 1, 1, 0, 0);
        push_ro(0, 7, 16);
        push_done();
        READOUT_ACK = 1'b1;
        pulse_start();
        wait_idle(100);
        READOUT_ACK = 1'b0;
        cycles(3);

        // Handshake stall with a START attempt while busy.
        set_cfg(2, 1, 10, 31, 4, 4, 1);
        push_ro(0, 10, 16);
        push_ro(1, 9, 16);
        push_done();
        pulse_start();
        wait_req(100);
        stable = 1;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) begin
                set_cfg(1, 5, 3, 7, 0, 0, 0);
                START = 1'b1;
            end else begin
                START = 1'b0;
            end
            @(negedge CLK_IN);
            if (!READOUT_REQ || DRAIN_B || SUB_IDX != 0 || PHASE_SEL != 5'd10) stable = 0;
        end
        START = 1'b0;
        chk("stall_stable", stable, 1);
        pulse_ack();
        chk("stall_req_dropped", int'(READOUT_REQ), 0);
        wait_req(100);
        chk("stall_second_sub_idx", int'(SUB_IDX), 1);
        pulse_ack();
        wait_idle(20);
        chk("stall_duty_kept", int'(DUTY_SEL), 4);
        cycles(3);

`ifdef MOD_SEQ_ABORT_EN
        // ABORT in cycle 5 of EXPOSE: no READOUT_REQ and no DONE afterwards.
        set_cfg(2, 2, 6, 1, 2, 2, 0);
        pulse_start();
        wait_expose(20);
        cycles(4);
        ABORT = 1'b1; @(negedge CLK_IN); ABORT = 1'b0;
        chk_idle_outputs("abort");
        cycles(60);
        chk_idle_outputs("after_abort");
        // START beats ABORT in IDLE.
        START = 1'b1; ABORT = 1'b1; @(negedge CLK_IN);
        START = 1'b0; ABORT = 1'b0;
        chk("abort_start_wins_busy", int'(BUSY), 1);
        RST = 1'b1; @(negedge CLK_IN); RST = 1'b0;
        cycles(3);
`endif

        cycles(10);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
